gemm_cmd_parser: RTL



---
 rtl/gemm_pkg.sv | 36 +++
 rtl/gemm_cmd_done_tracker.sv | 30 +++
 rtl/gemm_cmd_parser.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared GEMM command types, parser state enum and header decode helpers
package gemm_pkg;

    typedef logic [7:0] cmd_op_s;

    localparam cmd_op_s OP_FETCH  = 8'hF0;
    localparam cmd_op_s OP_DISP   = 8'hF1;
    localparam cmd_op_s OP_TILE   = 8'hF2;
    localparam cmd_op_s OP_WAIT_D = 8'hF3;
    localparam cmd_op_s OP_WAIT_T = 8'hF4;

    typedef struct packed {
        logic [7:0] rsvd;
        logic [7:0] len;
        logic [7:0] id;
        cmd_op_s    op;
    } cmd_header_s;

    typedef enum logic [2:0] {HDR, PAY, ISSUE, WAIT_D, WAIT_T, SKIP} gemm_parser_state_e;

    // Payload length in bytes a well-formed command must carry; 0 marks an unknown op.
    function automatic logic [7:0] cmd_expected_len(cmd_op_s op, int unsigned pay_words);
        return (op == OP_FETCH || op == OP_DISP || op == OP_TILE) ? 8'(4 * pay_words) :
               (op == OP_WAIT_D || op == OP_WAIT_T) ? 8'd4 : 8'd0;
    endfunction

    function automatic logic cmd_header_ok(cmd_header_s h, int unsigned pay_words);
        return h.len != 8'd0 && h.len == cmd_expected_len(h.op, pay_words);
    endfunction

    // Words to discard after a malformed header: ceil(len/4).
    function automatic logic [7:0] cmd_skip_words(cmd_header_s h);
        return 8'((9'(h.len) + 9'd3) >> 2);
    endfunction

endpackage

// File: rtl/gemm_cmd_done_tracker.sv
// gemm_cmd_done_tracker: latches the latest completion ID and flags a match with the awaited ID
// Ports: i_clk/i_reset_n clock and async active-low reset; i_done/i_done_id completion pulse and ID;
//        i_wait_id ID being waited on; o_match set once a completion was seen and its ID equals i_wait_id.
module gemm_cmd_done_tracker #(
    parameter int ID_W = 8
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_done,
    input  logic [ID_W-1:0] i_done_id,
    input  logic [ID_W-1:0] i_wait_id,
    output logic            o_match
);

    logic [ID_W-1:0] done_id;
    logic            seen;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            done_id <= '0;
            seen    <= 1'b0;
        end else if (i_done) begin
            done_id <= i_done_id;
            seen    <= 1'b1;
        end
    end

    assign o_match = seen && (done_id == i_wait_id);

endmodule

// File: rtl/gemm_cmd_parser.sv
// gemm_cmd_parser: pops command words, issues fetch/disp/tile commands, resolves waits, skips malformed commands
// Ports: i_clk/i_reset_n clock and async active-low reset; i_cmd_word/i_cmd_valid/o_cmd_ready command FIFO pop;
//        o_{fetch,disp,tile}_valid / i_{fetch,disp,tile}_ready engine channels sharing o_cmd_id/o_cmd_pay;
//        i_{disp,tile}_done(_id) completion pulses; o_idle parser waiting for a header; o_err malformed pulse.
// GEMM_CMD_PARSER_ERR_LOG_EN adds o_err_cnt (saturating error count) and o_err_last_hdr (last bad header).
module gemm_cmd_parser
    import gemm_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int ID_W      = 8,
    parameter int PAY_WORDS = 3,
    parameter int NUM_COLS  = 24
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [WORD_W-1:0]           i_cmd_word,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    output logic                        o_fetch_valid,
    output logic                        o_disp_valid,
    output logic                        o_tile_valid,
    input  logic                        i_fetch_ready,
    input  logic                        i_disp_ready,
    input  logic                        i_tile_ready,
    output logic [ID_W-1:0]             o_cmd_id,
    output logic [PAY_WORDS*WORD_W-1:0] o_cmd_pay,
    input  logic                        i_disp_done,
    input  logic                        i_tile_done,
    input  logic [ID_W-1:0]             i_disp_done_id,
    input  logic [ID_W-1:0]             i_tile_done_id,
    output logic                        o_idle,
    output logic                        o_err
`ifdef GEMM_CMD_PARSER_ERR_LOG_EN
    ,
    output logic [15:0]                 o_err_cnt,
    output logic [WORD_W-1:0]           o_err_last_hdr
`endif
);

    localparam int IDX_W = PAY_WORDS > 1 ? $clog2(PAY_WORDS) : 1;
    localparam logic [23:0] COL_EN_MASK = 24'hFFFFFF >> (24 - NUM_COLS);
    localparam logic [WORD_W-1:0] WORD3_MASK = WORD_W'({COL_EN_MASK, 8'hFF});

    gemm_parser_state_e state;
    cmd_op_s            op;
    logic [7:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  pay_q [PAY_WORDS];
    logic [WORD_W-1:0]  pay_word;
    logic [7:0]         skip_words;
    logic               pop, hdr_ok, err_hit, accept, disp_match, tile_match;

    assign pop        = i_cmd_valid && o_cmd_ready;
    assign hdr_ok     = cmd_header_ok(cmd_header_s'(i_cmd_word[31:0]), PAY_WORDS);
    assign skip_words = cmd_skip_words(cmd_header_s'(i_cmd_word[31:0]));
    assign err_hit    = state == HDR && pop && !hdr_ok;
    assign accept     = (o_fetch_valid && i_fetch_ready) || (o_disp_valid && i_disp_ready) ||
                        (o_tile_valid && i_tile_ready);

    // Column enables in Word3[31:8] are trimmed to the columns that exist before disp/tile issue.
    assign pay_word = (PAY_WORDS >= 3 && (op == OP_DISP || op == OP_TILE) && idx == IDX_W'(2)) ?
                      (i_cmd_word & WORD3_MASK) : i_cmd_word;

    for (genvar w = 0; w < PAY_WORDS; w++) begin : g_pay
        assign o_cmd_pay[w*WORD_W +: WORD_W] = pay_q[w];
    end

    // Wait IDs arrive as payload Word1; completions are compared against registered IDs only.
    gemm_cmd_done_tracker #(.ID_W(ID_W)) u_disp_done (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_done    (i_disp_done),
        .i_done_id (i_disp_done_id),
        .i_wait_id (pay_q[0][ID_W-1:0]),
        .o_match   (disp_match)
    );

    gemm_cmd_done_tracker #(.ID_W(ID_W)) u_tile_done (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_done    (i_tile_done),
        .i_done_id (i_tile_done_id),
        .i_wait_id (pay_q[0][ID_W-1:0]),
        .o_match   (tile_match)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= HDR;
            op            <= '0;
            cnt           <= '0;
            idx           <= '0;
            o_cmd_ready   <= 1'b0;
            o_fetch_valid <= 1'b0;
            o_disp_valid  <= 1'b0;
            o_tile_valid  <= 1'b0;
            o_cmd_id      <= '0;
            o_idle        <= 1'b1;
            o_err         <= 1'b0;
            for (int k = 0; k < PAY_WORDS; k++) pay_q[k] <= '0;
        end else begin
            o_err <= 1'b0;
            case (state)
                HDR: begin
                    o_cmd_ready <= 1'b1;
                    o_idle      <= 1'b1;
                    if (pop) begin
                        op       <= i_cmd_word[7:0];
                        o_cmd_id <= i_cmd_word[8 +: ID_W];
                        idx      <= '0;
                        if (hdr_ok) begin
                            state  <= PAY;
                            cnt    <= i_cmd_word[23:16] >> 2;
                            o_idle <= 1'b0;
                        end else begin
                            o_err <= 1'b1;
                            cnt   <= skip_words;
                            // A zero-length malformed command has nothing to skip.
                            if (skip_words != 8'd0) begin
                                state  <= SKIP;
                                o_idle <= 1'b0;
                            end
                        end
                    end
                end
                PAY: if (pop) begin
                    pay_q[idx] <= pay_word;
                    idx        <= idx + IDX_W'(1);
                    cnt        <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        o_cmd_ready   <= 1'b0;
                        o_fetch_valid <= op == OP_FETCH;
                        o_disp_valid  <= op == OP_DISP;
                        o_tile_valid  <= op == OP_TILE;
                        state         <= op == OP_WAIT_D ? WAIT_D : op == OP_WAIT_T ? WAIT_T : ISSUE;
                    end
                end
                ISSUE: if (accept) begin
                    o_fetch_valid <= 1'b0;
                    o_disp_valid  <= 1'b0;
                    o_tile_valid  <= 1'b0;
                    o_cmd_ready   <= 1'b1;
                    o_idle        <= 1'b1;
                    state         <= HDR;
                end
                WAIT_D, WAIT_T: if (state == WAIT_D ? disp_match : tile_match) begin
                    o_cmd_ready <= 1'b1;
                    o_idle      <= 1'b1;
                    state       <= HDR;
                end
                SKIP: if (pop) begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        o_idle <= 1'b1;
                        state  <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

`ifdef GEMM_CMD_PARSER_ERR_LOG_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err_cnt      <= '0;
            o_err_last_hdr <= '0;
        end else if (err_hit) begin
            o_err_cnt      <= o_err_cnt == 16'hFFFF ? o_err_cnt : o_err_cnt + 16'd1;
            o_err_last_hdr <= i_cmd_word;
        end
    end
`else
    logic unused_err_hit;
    assign unused_err_hit = err_hit;
`endif

endmodule
